// File: rtl/mtr_drv_pkg.sv
// Shared types and defaults for the motor-drive gate path.
package mtr_drv_pkg;

  typedef enum logic [2:0] {
    DEAD    = 3'd0,
    HIGH_ON = 3'd1,
    LOW_ON  = 3'd2,
    KILLED  = 3'd3,
    FAULT   = 3'd4
  } nonovl_state_t;

  localparam int DEADTIME_DFLT  = 32;
  localparam int OVR_LIMIT_DFLT = 8;

endpackage

// File: rtl/dead_timer.sv
// Dead-time counter: synchronous clear, increment enable, flag on the last dead cycle.
module dead_timer #(
  parameter int DEAD_W   = 6,
  parameter int DEADTIME = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [DEAD_W-1:0] LAST = DEAD_W'(DEADTIME - 1);

  logic [DEAD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + DEAD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/pwm_nonoverlap.sv
// Non-overlapping high/low gate drive with dead time, cycle-by-cycle
// overcurrent limiting and a latched fault after consecutive tripped periods.
module pwm_nonoverlap
  import mtr_drv_pkg::*;
#(
  parameter int DEAD_W    = 6,
  parameter int DEADTIME  = DEADTIME_DFLT,
  parameter int OVR_W     = 4,
  parameter int OVR_LIMIT = OVR_LIMIT_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic PWM_sig,
  input  logic PWM_synch,
  input  logic OVR_I_blank_n,
  input  logic OVR_I,
  input  logic clr_fault,
  output logic high_out,
  output logic low_out,
  output logic ovr_trip,
  output logic fault
);

  localparam logic [OVR_W-1:0] OVR_MAX = OVR_W'(OVR_LIMIT);

  nonovl_state_t    state_q, state_d;
  logic             pwm_prev_q;
  logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d, ovr_cnt_inc;
  logic             trip_flag_q, trip_flag_d;
  logic             fault_q, fault_d;
  logic             high_out_q, low_out_q, ovr_trip_q;
  logic             pwm_edge, trip, fault_entry;
  logic             dt_clr, dt_inc, dt_expired;

  assign pwm_edge    = PWM_sig ^ pwm_prev_q;
  assign trip        = (state_q == HIGH_ON) && OVR_I && OVR_I_blank_n;
  assign ovr_cnt_inc = (ovr_cnt_q == OVR_MAX) ? ovr_cnt_q : ovr_cnt_q + OVR_W'(1);
  assign fault_entry = trip && (ovr_cnt_inc == OVR_MAX);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FAULT: begin
        if (clr_fault) state_d = DEAD;
      end
      default: begin
        if (fault_entry)              state_d = FAULT;
        else if (trip)                state_d = KILLED;
        else if (state_q == KILLED) begin
          if (PWM_synch)              state_d = DEAD;
        end
        else if (pwm_edge)            state_d = DEAD;
        else if ((state_q == DEAD) && dt_expired)
          state_d = PWM_sig ? HIGH_ON : LOW_ON;
      end
    endcase
  end

  // Counter restarts on every entry into DEAD and on any edge while dead.
  assign dt_clr = (state_d != DEAD) || (state_q != DEAD) || pwm_edge;
  assign dt_inc = (state_q == DEAD);

  dead_timer #(
    .DEAD_W  (DEAD_W),
    .DEADTIME(DEADTIME)
  ) u_dead_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (dt_clr),
    .inc    (dt_inc),
    .expired(dt_expired)
  );

  always_comb begin
    ovr_cnt_d   = ovr_cnt_q;
    trip_flag_d = trip_flag_q;
    fault_d     = fault_q;
    if (state_q == FAULT) begin
      if (clr_fault) begin
        fault_d     = 1'b0;
        ovr_cnt_d   = '0;
        trip_flag_d = 1'b0;
      end
    end else begin
      if (trip)                             ovr_cnt_d = ovr_cnt_inc;
      else if (clr_fault)                   ovr_cnt_d = '0;
      else if (PWM_synch && !trip_flag_q)   ovr_cnt_d = '0;
      // A trip landing on the period boundary is charged to the new period.
      if (PWM_synch) trip_flag_d = trip;
      else if (trip) trip_flag_d = 1'b1;
      if (fault_entry) fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DEAD;
      pwm_prev_q  <= 1'b0;
      ovr_cnt_q   <= '0;
      trip_flag_q <= 1'b0;
      fault_q     <= 1'b0;
      high_out_q  <= 1'b0;
      low_out_q   <= 1'b0;
      ovr_trip_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwm_prev_q  <= PWM_sig;
      ovr_cnt_q   <= ovr_cnt_d;
      trip_flag_q <= trip_flag_d;
      fault_q     <= fault_d;
      // Gating with both current and next state drops a gate on the same edge
      // that leaves the on-state, while still delaying rise by one cycle.
      high_out_q  <= (state_q == HIGH_ON) && (state_d == HIGH_ON);
      low_out_q   <= (state_q == LOW_ON) && (state_d == LOW_ON);
      ovr_trip_q  <= trip;
    end
  end

  assign high_out = high_out_q;
  assign low_out  = low_out_q;
  assign ovr_trip = ovr_trip_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_pwm_nonoverlap.sv
// Directed phases plus randomized PWM/overcurrent traffic checked every cycle
// against a time-based reference model of the gate driver.
module tb_pwm_nonoverlap;

  localparam int D = 32;
  localparam int L = 8;

  logic clk = 1'b0;
  logic rst, PWM_sig, PWM_synch, OVR_I_blank_n, OVR_I, clr_fault;
  logic high_out, low_out, ovr_trip, fault;

  always #5 clk = ~clk;

  pwm_nonoverlap #(
    .DEAD_W   (6),
    .DEADTIME (D),
    .OVR_W    (4),
    .OVR_LIMIT(L)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .PWM_sig      (PWM_sig),
    .PWM_synch    (PWM_synch),
    .OVR_I_blank_n(OVR_I_blank_n),
    .OVR_I        (OVR_I),
    .clr_fault    (clr_fault),
    .high_out     (high_out),
    .low_out      (low_out),
    .ovr_trip     (ovr_trip),
    .fault        (fault)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: gates are described by the cycle at which the current
  // dead interval started (r) and the PWM level held since then (lvl).
  int n = 0;
  int r = 0;
  int cnt = 0;
  bit act = 1'b1, kil = 1'b0, flt = 1'b0, lvl = 1'b0, prev = 1'b0, flag = 1'b0;
  bit e_hi = 1'b0, e_lo = 1'b0, e_trip = 1'b0;

  int ph = 0, period = 100, duty = 70, ovr_mode = 0;
  bit rnd_duty = 1'b0;

  task automatic chk(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, got, exp, n);
    end
  endtask

  task automatic model_step();
    bit hi_on, trp, edg;
    int nc;
    n++;
    e_trip = 1'b0;
    if (rst) begin
      r = n; act = 1'b1; kil = 1'b0; flt = 1'b0; lvl = 1'b0;
      prev = 1'b0; flag = 1'b0; cnt = 0;
    end else begin
      if (flt) begin
        if (clr_fault) begin
          flt = 1'b0; cnt = 0; flag = 1'b0; act = 1'b1; r = n; lvl = PWM_sig;
        end
      end else begin
        edg   = (PWM_sig != prev);
        hi_on = act && lvl && ((n - 1) >= (r + D));
        trp   = hi_on && OVR_I && OVR_I_blank_n;
        e_trip = trp;
        nc = cnt;
        if (trp) nc = (cnt < L) ? cnt + 1 : cnt;
        else if (clr_fault || (PWM_synch && !flag)) nc = 0;
        flag = PWM_synch ? trp : (flag || trp);
        cnt = nc;
        if (trp) begin
          act = 1'b0;
          if (cnt == L) flt = 1'b1;
          else kil = 1'b1;
        end else if (kil) begin
          if (PWM_synch) begin
            kil = 1'b0; act = 1'b1; r = n; lvl = PWM_sig;
          end
        end else if (edg) begin
          r = n; lvl = PWM_sig;
        end
      end
      prev = PWM_sig;
    end
    e_hi = act && lvl && (n >= r + D + 1);
    e_lo = act && !lvl && (n >= r + D + 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("high_out", high_out, e_hi);
    chk("low_out", low_out, e_lo);
    chk("ovr_trip", ovr_trip, e_trip);
    chk("fault", fault, flt);
    chk("no_overlap", high_out && low_out, 1'b0);
  endtask

  task automatic gen();
    if (ph == 0 && rnd_duty) duty = $urandom_range(40, 90);
    PWM_synch = (ph == period - 1);
    PWM_sig   = (ph < duty);
    case (ovr_mode)
      1: begin OVR_I = 1'b1; OVR_I_blank_n = 1'b1; end
      2: begin
        OVR_I         = ($urandom_range(0, 199) == 0);
        OVR_I_blank_n = ($urandom_range(0, 3) != 0);
        clr_fault     = ($urandom_range(0, 499) == 0);
      end
      3: begin OVR_I = (ph == period - 1); OVR_I_blank_n = 1'b1; end
      default: begin OVR_I = 1'b0; OVR_I_blank_n = 1'b1; end
    endcase
    cyc();
    clr_fault = 1'b0;
    ph = (ph + 1) % period;
  endtask

  task automatic run_periods(input int k, input int mode);
    ovr_mode = mode;
    repeat (k * period) gen();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; PWM_sig = 1'b0; PWM_synch = 1'b0; OVR_I = 1'b0;
    OVR_I_blank_n = 1'b1; clr_fault = 1'b0;
    repeat (3) cyc();
    chk("reset_high", high_out, 1'b0);
    chk("reset_low", low_out, 1'b0);
    chk("reset_fault", fault, 1'b0);
    rst = 1'b0;

    // Low side comes up after a full dead time following reset.
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 32) chk("rst_low_pre", low_out, 1'b0);
      if (i == 33) chk("rst_low_rise", low_out, 1'b1);
    end

    // Single rising edge: low drops at once, high rises 33 cycles later.
    PWM_sig = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 1)  chk("edge_low_drop", low_out, 1'b0);
      if (i == 33) chk("edge_high_pre", high_out, 1'b0);
      if (i == 34) chk("edge_high_rise", high_out, 1'b1);
    end

    // Glitch: short high pulse restarts dead time, high never asserts.
    PWM_sig = 1'b0;
    repeat (40) cyc();
    PWM_sig = 1'b1;
    repeat (10) cyc();
    PWM_sig = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 33) chk("glitch_low_pre", low_out, 1'b0);
      if (i == 34) chk("glitch_low_rise", low_out, 1'b1);
    end

    // Blanked overcurrent is ignored; unblanked trips and kills high side.
    PWM_sig = 1'b1;
    repeat (40) cyc();
    OVR_I = 1'b1; OVR_I_blank_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("blank_no_trip", ovr_trip, 1'b0);
    end
    OVR_I_blank_n = 1'b1;
    cyc();
    chk("trip_pulse", ovr_trip, 1'b1);
    chk("trip_high_off", high_out, 1'b0);
    OVR_I = 1'b0;
    cyc();
    chk("trip_pulse_end", ovr_trip, 1'b0);
    repeat (20) cyc();
    PWM_synch = 1'b1;
    cyc();
    PWM_synch = 1'b0;
    for (int i = 1; i <= 34; i++) begin
      cyc();
      if (i == 32) chk("resume_high_pre", high_out, 1'b0);
      if (i == 33) chk("resume_high_rise", high_out, 1'b1);
    end

    // Randomized periods with sporadic overcurrent and fault clears.
    ph = 0; rnd_duty = 1'b1;
    run_periods(20, 2);

    // Seven tripped periods, one clean, seven more: no fault.
    rnd_duty = 1'b0; duty = 70; ovr_mode = 0;
    clr_fault = 1'b1;
    gen();
    while (ph != 0) gen();
    run_periods(7, 1);
    run_periods(1, 0);
    run_periods(7, 1);
    chk("seven_no_fault", fault, 1'b0);

    // Eight consecutive tripped periods latch the fault.
    run_periods(1, 0);
    run_periods(8, 1);
    chk("eight_fault", fault, 1'b1);
    rnd_duty = 1'b1;
    run_periods(3, 0);
    chk("fault_held", fault, 1'b1);
    clr_fault = 1'b1;
    gen();
    chk("fault_cleared", fault, 1'b0);
    run_periods(2, 0);

    // Trips coinciding with the period pulse are counted once each.
    rnd_duty = 1'b0;
    while (ph != 0) gen();
    duty = period;
    run_periods(6, 3);
    chk("synch_trip_no_fault", fault, 1'b0);

    // Reset while the high side is on clears state and counter.
    ovr_mode = 0;
    repeat (40) gen();
    chk("pre_reset_high", high_out, 1'b1);
    rst = 1'b1;
    gen();
    chk("reset_mid_high", high_out, 1'b0);
    chk("reset_mid_fault", fault, 1'b0);
    rst = 1'b0;
    while (ph != 0) gen();
    duty = 70;
    run_periods(7, 1);
    chk("post_reset_no_fault", fault, 1'b0);
    rnd_duty = 1'b1;
    run_periods(5, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_nonoverlap.md
Name: pwm_nonoverlap

Overview:
Downstream stage of the 11-bit PWM generator in the motor-drive path. Consumes PWM_sig, PWM_synch and OVR_I_blank_n, and produces non-overlapping high-side and low-side gate commands with programmable dead time. Adds cycle-by-cycle overcurrent limiting and a latched fault after a run of consecutive tripped PWM periods.

Parameters:
DEAD_W, 6, width of the dead-time counter
DEADTIME, 32, dead time in clk cycles (1..2**DEAD_W-1)
OVR_W, 4, width of the consecutive-trip counter
OVR_LIMIT, 8, consecutive tripped PWM periods that latch fault (1..2**OVR_W-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
PWM_sig  in  1  raw PWM from the PWM generator (registered, synchronous to clk)
PWM_synch  in  1  one-cycle pulse marking the end of each PWM period
OVR_I_blank_n  in  1  high when the overcurrent comparator may be trusted
OVR_I  in  1  overcurrent comparator, already synchronized upstream
clr_fault  in  1  one-cycle request to clear a latched fault
high_out  out  1  high-side gate command (registered)
low_out  out  1  low-side gate command (registered)
ovr_trip  out  1  one-cycle pulse, registered, on each cycle-by-cycle trip
fault  out  1  latched overcurrent fault (registered)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (rst). All flops update on posedge clk only.
- Reset values: high_out=0, low_out=0, ovr_trip=0, fault=0. State=DEAD, dead counter=0, pwm_prev=0, ovr_cnt=0, trip_flag=0.
- Edge detect: pwm_prev<=PWM_sig every cycle. An edge is PWM_sig!=pwm_prev.
- States: DEAD, HIGH_ON, LOW_ON, KILLED, FAULT.
- Priority per cycle, highest first: rst > fault entry > trip > PWM_synch exit of KILLED > edge > dead-counter expiry.
- DEAD:
  - Both outputs 0. The counter increments each cycle.
  - When the counter reaches DEADTIME-1, the next state is HIGH_ON if PWM_sig=1, else LOW_ON.
  - The corresponding output rises DEADTIME+1 cycles after the edge was sampled.
  - An edge seen while in DEAD restarts the counter at 0.
- HIGH_ON / LOW_ON:
  - Outputs are high_out=1 / low_out=1 respectively.
  - An edge moves to DEAD with counter=0. Both outputs are 0 on the following cycle.
- Trip condition: state==HIGH_ON && OVR_I && OVR_I_blank_n. On a trip:
  - Next state KILLED; high_out drops next cycle; ovr_trip pulses once.
  - trip_flag set; ovr_cnt increments, saturating at OVR_LIMIT.
  - Trips are only possible in HIGH_ON. LOW_ON ignores OVR_I.
- KILLED:
  - Both outputs 0. Edges are ignored.
  - On PWM_synch, go to DEAD with counter=0, then resolve per PWM_sig as in DEAD.
- PWM_synch counter bookkeeping:
  - If trip_flag=0 and no trip occurs in the same cycle, ovr_cnt clears.
  - trip_flag then clears unless a trip occurs in that same cycle.
  - A trip coinciding with PWM_synch counts in the new period, and the block stays KILLED until the next PWM_synch.
- Fault entry: the trip that makes ovr_cnt==OVR_LIMIT sets fault=1 on the same edge and enters FAULT instead of KILLED.
- FAULT:
  - Both outputs 0; ignores PWM_sig, PWM_synch and OVR_I.
  - clr_fault: fault<=0, ovr_cnt<=0, trip_flag<=0, state DEAD with counter=0.
  - clr_fault outside FAULT clears ovr_cnt only.
- Invariant: high_out && low_out is never 1 on any cycle, including across reset.
- Reset mid-operation: outputs drop on the next edge. After rst deasserts, full DEADTIME elapses before either output asserts.

Decomposition:
- Shared package mtr_drv_pkg:
  - typedef enum logic[2:0] nonovl_state_t {DEAD, HIGH_ON, LOW_ON, KILLED, FAULT}.
  - localparams DEADTIME_DFLT=32, OVR_LIMIT_DFLT=8.
- One sub-module: dead_timer (DEAD_W-bit counter with sync clear, increment enable and expired flag at DEADTIME-1).
- Edge detect, trip logic and the FSM stay in pwm_nonoverlap.

Test Plan:
- Reset then PWM_sig=0 held -> low_out=0 for 32 cycles after rst falls, low_out=1 on cycle 33; high_out stays 0.
- Single PWM_sig 0->1 edge -> low_out=0 one cycle after the sampled edge; high_out=1 exactly 33 cycles after the edge; never both 1.
- Glitch: PWM_sig high for 10 cycles then low -> dead counter restarts on the second edge; high_out never asserts; low_out=1 33 cycles after the second edge.
- OVR_I=1 with OVR_I_blank_n=0 in HIGH_ON -> no trip. With OVR_I_blank_n=1 -> high_out=0 next cycle and ovr_trip one-cycle pulse. Output stays off until PWM_synch, then high_out=1 33 cycles later if PWM_sig=1.
- Trip in 7 consecutive periods, then 1 clean period -> ovr_cnt returns to 0 and fault stays 0. Trip in 8 consecutive periods -> fault=1 on the 8th trip edge, both outputs 0. Outputs stay 0 despite PWM activity until clr_fault, after which DEAD 32 cycles then normal.
- Trip coincident with PWM_synch -> counted once, stays KILLED through the next PWM_synch. rst asserted in HIGH_ON -> high_out=0 next cycle, fault=0, ovr_cnt=0.
